// File: rtl/esm_pkg.sv
// Shared types for the dependency issue scheduler: per-slot lifecycle state and
// an index-width helper.
package esm_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    WAIT   = 2'd1,
    ISSUED = 2'd2
  } slot_state_e;

  function automatic int idx_bits(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/dep_issue_scheduler_if.sv
// Bundle of allocation, issue handshake, completion and status signals between
// dispatch/execution (master) and the scheduler (slave).
interface dep_issue_scheduler_if
  import esm_pkg::*;
#(
  parameter int BS = 16
);
  localparam int BS_BITS = idx_bits(BS);

  logic               alloc_valid;
  logic [BS_BITS-1:0] alloc_idx;
  logic [BS-1:0]      alloc_dep;
  logic               issue_valid;
  logic [BS_BITS-1:0] issue_idx;
  logic               issue_ready;
  logic               cmpl_valid;
  logic [BS_BITS-1:0] cmpl_idx;
  logic [BS_BITS:0]   occupancy;
  logic               full;
  logic               err;

  modport master (
    output alloc_valid, alloc_idx, alloc_dep, issue_ready, cmpl_valid, cmpl_idx,
    input  issue_valid, issue_idx, occupancy, full, err
  );

  modport slave (
    input  alloc_valid, alloc_idx, alloc_dep, issue_ready, cmpl_valid, cmpl_idx,
    output issue_valid, issue_idx, occupancy, full, err
  );

endinterface

// File: rtl/dep_issue_scheduler_rr_pick.sv
// Round-robin picker: first requesting index at or after i_ptr, wrapping.
// Rotates the request vector, priority-encodes the lowest bit, then un-rotates.
module rr_pick
  import esm_pkg::*;
#(
  parameter  int N = 16,
  localparam int W = idx_bits(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_gnt_valid,
  output logic [W-1:0] o_gnt_idx
);

  logic [N-1:0] w_rot;
  logic [W-1:0] w_off;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_rot
      // N is a power of two, so the index sum wraps naturally.
      assign w_rot[gi] = i_req[i_ptr + W'(gi)];
    end
  endgenerate

  always_comb begin
    w_off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off = W'(j);
      end
    end
  end

  assign o_gnt_valid = |i_req;
  assign o_gnt_idx   = i_ptr + w_off;

endmodule

// File: rtl/dep_issue_scheduler.sv
// Dependency-tracking issue scheduler: a BS x BS wait matrix gates each buffered
// slot until every older slot it depends on has completed, then offers it round-robin.
module dep_issue_scheduler
  import esm_pkg::*;
#(
  parameter int BS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dep_issue_scheduler_if.slave  bus
);

  localparam int BS_BITS = idx_bits(BS);

  slot_state_e        r_state      [BS];
  slot_state_e        w_state_next [BS];
  logic [BS-1:0]      r_row        [BS];
  logic [BS-1:0]      w_row_next   [BS];
  logic [BS_BITS:0]   r_occ;
  logic               r_issue_valid;
  logic [BS_BITS-1:0] r_issue_idx;
  logic [BS_BITS-1:0] r_ptr;
  logic               r_err;

  logic               w_hs;
  logic               w_cmpl_ok;
  logic               w_alloc_ok;
  logic [BS-1:0]      w_live;
  logic [BS-1:0]      w_req;
  logic [BS-1:0]      w_alloc_row;
  logic [BS_BITS-1:0] w_sel_ptr;
  logic               w_gnt_valid;
  logic [BS_BITS-1:0] w_gnt_idx;

  assign w_hs      = r_issue_valid && bus.issue_ready;
  assign w_cmpl_ok = bus.cmpl_valid && (r_state[bus.cmpl_idx] == ISSUED);
  // A slot freed by completion in this same cycle is a legal allocation target.
  assign w_alloc_ok = bus.alloc_valid &&
                      ((r_state[bus.alloc_idx] == EMPTY) ||
                       (w_cmpl_ok && (bus.cmpl_idx == bus.alloc_idx)));
  assign w_alloc_row = bus.alloc_dep & w_live & ~(BS'(1) << bus.alloc_idx);

  genvar gi;
  generate
    for (gi = 0; gi < BS; gi++) begin : g_slot
      assign w_live[gi] = (r_state[gi] != EMPTY) &&
                          !(w_cmpl_ok && (bus.cmpl_idx == BS_BITS'(gi)));
      // The slot being accepted this edge must not be offered again on reload.
      assign w_req[gi]  = (r_state[gi] == WAIT) && (r_row[gi] == '0) &&
                          !(w_hs && (r_issue_idx == BS_BITS'(gi)));
    end
  endgenerate

  assign w_sel_ptr = w_hs ? (r_issue_idx + BS_BITS'(1)) : r_ptr;

  rr_pick #(
    .N (BS)
  ) u_pick (
    .i_req       (w_req),
    .i_ptr       (w_sel_ptr),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_idx   (w_gnt_idx)
  );

  always_comb begin
    for (int k = 0; k < BS; k++) begin
      w_state_next[k] = r_state[k];
      w_row_next[k]   = r_row[k];
      if (w_cmpl_ok) begin
        w_row_next[k][bus.cmpl_idx] = 1'b0;
      end
      if (w_cmpl_ok && (bus.cmpl_idx == BS_BITS'(k))) begin
        w_state_next[k] = EMPTY;
      end
      if (w_alloc_ok && (bus.alloc_idx == BS_BITS'(k))) begin
        w_state_next[k] = WAIT;
        w_row_next[k]   = w_alloc_row;
      end
      if (w_hs && (r_issue_idx == BS_BITS'(k))) begin
        w_state_next[k] = ISSUED;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < BS; k++) begin
        r_state[k] <= EMPTY;
        r_row[k]   <= '0;
      end
      r_occ         <= '0;
      r_issue_valid <= 1'b0;
      r_issue_idx   <= '0;
      r_ptr         <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_row   <= w_row_next;

      case ({w_alloc_ok, w_cmpl_ok})
        2'b10:   r_occ <= r_occ + (BS_BITS+1)'(1);
        2'b01:   r_occ <= r_occ - (BS_BITS+1)'(1);
        default: r_occ <= r_occ;
      endcase

      if (!r_issue_valid || w_hs) begin
        r_issue_valid <= w_gnt_valid;
        if (w_gnt_valid) begin
          r_issue_idx <= w_gnt_idx;
        end
      end

      if (w_hs) begin
        r_ptr <= r_issue_idx + BS_BITS'(1);
      end

      if ((bus.alloc_valid && !w_alloc_ok) || (bus.cmpl_valid && !w_cmpl_ok)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.issue_valid = r_issue_valid;
  assign bus.issue_idx   = r_issue_idx;
  assign bus.occupancy   = r_occ;
  assign bus.full        = (r_occ == (BS_BITS+1)'(BS));
  assign bus.err         = r_err;

endmodule

// File: tb/tb_dep_issue_scheduler.sv
// Bench for dep_issue_scheduler: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a slot/dependency-set reference model.
module tb_dep_issue_scheduler;
  import esm_pkg::*;

  localparam int BS      = 16;
  localparam int BS_BITS = idx_bits(BS);

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  dep_issue_scheduler_if #(.BS(BS)) bus ();

  dep_issue_scheduler #(.BS(BS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = empty, 1 = waiting, 2 = issued; m_on[k][j] = k waits on j.
  int m_st [BS];
  bit m_on [BS][BS];
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_occ;
  bit m_err;

  task automatic check(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < BS; k++) begin
      m_st[k] = 0;
      for (int j = 0; j < BS; j++) m_on[k][j] = 1'b0;
    end
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
    m_occ   = 0;
    m_err   = 1'b0;
  endtask

  function automatic bit m_ready(input int k);
    bit r;
    r = (m_st[k] == 1);
    for (int j = 0; j < BS; j++) if (m_on[k][j]) r = 1'b0;
    return r;
  endfunction

  task automatic model_step(input bit av, input int ai, input logic [BS-1:0] ad,
                            input bit ir, input bit cv, input int ci);
    bit hs, c_ok, a_ok, reload;
    int sel, pick, k;
    hs     = m_valid && ir;
    c_ok   = cv && (m_st[ci] == 2);
    a_ok   = av && ((m_st[ai] == 0) || (c_ok && ci == ai));
    if ((cv && !c_ok) || (av && !a_ok)) m_err = 1'b1;
    reload = !m_valid || hs;
    sel    = hs ? (m_idx + 1) % BS : m_ptr;
    pick   = -1;
    if (reload) begin
      for (int j = 0; j < BS; j++) begin
        k = (sel + j) % BS;
        if (pick < 0 && m_ready(k) && !(hs && k == m_idx)) pick = k;
      end
    end
    if (hs) begin
      m_st[m_idx] = 2;
      m_ptr       = sel;
    end
    if (c_ok) begin
      m_st[ci] = 0;
      for (int r = 0; r < BS; r++) m_on[r][ci] = 1'b0;
      m_occ--;
    end
    if (a_ok) begin
      for (int j = 0; j < BS; j++) m_on[ai][j] = ad[j] && (j != ai) && (m_st[j] != 0);
      m_st[ai] = 1;
      m_occ++;
    end
    if (reload) begin
      m_valid = (pick >= 0);
      if (pick >= 0) m_idx = pick;
    end
  endtask

  task automatic compare_all();
    check("issue_valid", int'(bus.issue_valid), int'(m_valid));
    if (m_valid) check("issue_idx", int'(bus.issue_idx), m_idx);
    check("occupancy", int'(bus.occupancy), m_occ);
    check("full", int'(bus.full), int'(m_occ == BS));
    check("err", int'(bus.err), int'(m_err));
  endtask

  task automatic step(input bit av, input int ai, input logic [BS-1:0] ad,
                      input bit ir, input bit cv, input int ci);
    bus.alloc_valid = av;
    bus.alloc_idx   = BS_BITS'(ai);
    bus.alloc_dep   = ad;
    bus.issue_ready = ir;
    bus.cmpl_valid  = cv;
    bus.cmpl_idx    = BS_BITS'(ci);
    $display("cyc %0d alloc=%0b/%0d dep=%h issue=%0b/%0d rdy=%0b cmpl=%0b/%0d",
             cyc, av, ai, ad, m_valid, m_idx, ir, cv, ci);
    model_step(av, ai, ad, ir, cv, ci);
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic idle(input bit ir);
    step(1'b0, 0, '0, ir, 1'b0, 0);
  endtask

  // Asserts rst between edges and checks the outputs clear without a clock edge.
  task automatic async_reset(input string tag);
    bus.alloc_valid = 1'b0;
    bus.issue_ready = 1'b0;
    bus.cmpl_valid  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_valid"}, int'(bus.issue_valid), 0);
    check({tag, "_idx"},   int'(bus.issue_idx),   0);
    check({tag, "_occ"},   int'(bus.occupancy),   0);
    check({tag, "_full"},  int'(bus.full),        0);
    check({tag, "_err"},   int'(bus.err),         0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("cyc %0d reset released", cyc);
  endtask

  initial begin
    int q[$];
    bit av, ir, cv, legal_only;
    int ai, ci;
    logic [BS-1:0] ad;

    rst             = 1'b1;
    bus.alloc_valid = 1'b0;
    bus.alloc_idx   = '0;
    bus.alloc_dep   = '0;
    bus.issue_ready = 1'b0;
    bus.cmpl_valid  = 1'b0;
    bus.cmpl_idx    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();

    // Independent slots issue back to back.
    step(1'b1, 0, '0, 1'b1, 1'b0, 0);
    check("t2_none_yet", int'(bus.issue_valid), 0);
    step(1'b1, 1, '0, 1'b1, 1'b0, 0);
    check("t2_idx0", int'(bus.issue_idx), 0);
    step(1'b1, 2, '0, 1'b1, 1'b0, 0);
    check("t2_idx1", int'(bus.issue_idx), 1);
    idle(1'b1);
    check("t2_idx2", int'(bus.issue_idx), 2);
    idle(1'b1);
    check("t2_drained", int'(bus.issue_valid), 0);
    for (int s = 0; s < 3; s++) step(1'b0, 0, '0, 1'b1, 1'b1, s);
    check("t2_occ", int'(bus.occupancy), 0);

    // Dependency chain 4 -> 3.
    step(1'b1, 3, '0, 1'b1, 1'b0, 0);
    step(1'b1, 4, 16'h0008, 1'b1, 1'b0, 0);
    check("t3_idx3", int'(bus.issue_idx), 3);
    idle(1'b1);
    check("t3_blocked", int'(bus.issue_valid), 0);
    idle(1'b1);
    idle(1'b1);
    check("t3_still_blocked", int'(bus.issue_valid), 0);
    step(1'b0, 0, '0, 1'b1, 1'b1, 3);
    check("t3_not_same_edge", int'(bus.issue_valid), 0);
    idle(1'b0);
    check("t3_unblocked_v", int'(bus.issue_valid), 1);
    check("t3_unblocked_idx", int'(bus.issue_idx), 4);
    idle(1'b1);
    step(1'b0, 0, '0, 1'b1, 1'b1, 4);

    // Stale dependencies on empty slots are dropped.
    step(1'b1, 5, 16'hFFFF, 1'b1, 1'b0, 0);
    idle(1'b0);
    check("t4_idx5", int'(bus.issue_idx), 5);
    check("t4_err", int'(bus.err), 0);
    idle(1'b1);
    step(1'b0, 0, '0, 1'b1, 1'b1, 5);

    // Stalled offer stays stable while another slot becomes ready.
    step(1'b1, 6, '0, 1'b0, 1'b0, 0);
    step(1'b1, 2, '0, 1'b0, 1'b0, 0);
    for (int s = 0; s < 5; s++) begin
      idle(1'b0);
      check("t5_hold", int'(bus.issue_idx), 6);
    end
    idle(1'b1);
    check("t5_next", int'(bus.issue_idx), 2);
    idle(1'b1);
    step(1'b0, 0, '0, 1'b1, 1'b1, 6);
    step(1'b0, 0, '0, 1'b1, 1'b1, 2);

    // Completion and re-allocation of the same slot in one cycle.
    step(1'b1, 8, '0, 1'b1, 1'b0, 0);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, 8, 16'h0100, 1'b0, 1'b1, 8);
    check("t6_reuse_err", int'(bus.err), 0);
    check("t6_reuse_occ", int'(bus.occupancy), 1);
    idle(1'b0);
    check("t6_reuse_idx", int'(bus.issue_idx), 8);
    idle(1'b1);
    step(1'b0, 0, '0, 1'b1, 1'b1, 8);

    // Allocation into a waiting slot is rejected and flagged.
    step(1'b1, 7, '0, 1'b0, 1'b0, 0);
    step(1'b1, 7, 16'h00FF, 1'b0, 1'b0, 0);
    check("t6_dup_err", int'(bus.err), 1);
    check("t6_dup_occ", int'(bus.occupancy), 1);

    // Reset while an offer is pending.
    check("t1_pre_valid", int'(bus.issue_valid), 1);
    async_reset("t1");
    compare_all();

    // Completion of an empty slot.
    step(1'b0, 0, '0, 1'b0, 1'b1, 9);
    check("t6_cmpl_err", int'(bus.err), 1);
    check("t6_cmpl_occ", int'(bus.occupancy), 0);
    async_reset("rst2");

    // Randomized traffic: legal-only first, then with occasional protocol errors.
    for (int n = 0; n < 700; n++) begin
      legal_only = (n < 400);
      av = ($urandom % 3) != 0;
      ai = 0;
      if (av) begin
        if (legal_only || ($urandom % 8) != 0) begin
          q.delete();
          for (int k = 0; k < BS; k++) if (m_st[k] == 0) q.push_back(k);
          if (q.size() == 0) av = 1'b0;
          else ai = q[$urandom_range(q.size() - 1)];
        end else begin
          ai = int'($urandom % BS);
        end
      end
      ad = BS'($urandom & $urandom);
      ir = ($urandom % 4) != 0;
      cv = 1'b0;
      ci = 0;
      q.delete();
      for (int k = 0; k < BS; k++) if (m_st[k] == 2) q.push_back(k);
      if (q.size() != 0 && ($urandom % 2) != 0) begin
        cv = 1'b1;
        ci = q[$urandom_range(q.size() - 1)];
      end else if (!legal_only && ($urandom % 16) == 0) begin
        cv = 1'b1;
        ci = int'($urandom % BS);
      end
      step(av, ai, ad, ir, cv, ci);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
